// File: rtl/risc_v_mike_wb_pkg.sv
// Shared types for the write-back arbiter: request struct, source enum, widths.
package risc_v_mike_wb_pkg;

    localparam int DATA_32_W  = 32;
    localparam int REG_ADDR_W = 5;
    localparam int WB_NUM_SRC = 2;

    typedef logic [REG_ADDR_W-1:0] t_register_addr;

    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_LSU = 1'b1
    } t_wb_src;

    typedef struct packed {
        logic                 valid;
        t_register_addr       addr;
        logic [DATA_32_W-1:0] data;
    } t_wb_req;

    function automatic logic addr_in_range(input t_register_addr addr, input int depth);
        logic [31:0] addr_ext;
        logic [31:0] depth_ext;
        addr_ext  = {{(32-REG_ADDR_W){1'b0}}, addr};
        depth_ext = depth[31:0];
        return (addr_ext < depth_ext);
    endfunction

endpackage

// File: rtl/risc_v_mike_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; gnt is one-hot (bit 0 = ALU, bit 1 = LSU), zero in reset.
module risc_v_mike_rr_arb2
    import risc_v_mike_wb_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [WB_NUM_SRC-1:0] req_i,
    output logic [WB_NUM_SRC-1:0] gnt_o
);

    t_wb_src               last_grant_q;
    t_wb_src               last_grant_d;
    logic [WB_NUM_SRC-1:0] gnt_s;

    // Grant selection: a lone requester wins, a tie goes to whoever did not win last.
    always_comb begin
        gnt_s = 2'b00;
        case (req_i)
            2'b01:   gnt_s = 2'b01;
            2'b10:   gnt_s = 2'b10;
            2'b11:   gnt_s = (last_grant_q == WB_SRC_ALU) ? 2'b10 : 2'b01;
            default: gnt_s = 2'b00;
        endcase
        if (rst_i) begin
            gnt_o = 2'b00;
        end else begin
            gnt_o = gnt_s;
        end
    end

    // Arbitration history only moves on a grant.
    always_comb begin
        last_grant_d = last_grant_q;
        if (gnt_s[0]) begin
            last_grant_d = WB_SRC_ALU;
        end else if (gnt_s[1]) begin
            last_grant_d = WB_SRC_LSU;
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // Reset to LSU so the ALU wins the first tie.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_grant_q <= WB_SRC_LSU;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/risc_v_mike_wb_arbiter.sv
// Write-back arbiter: ALU vs LSU onto the single register-file write port.
// Optional decode bypass of the staged write under `MIKE_WB_BYPASS_EN.
module risc_v_mike_wb_arbiter
    import risc_v_mike_wb_pkg::*;
#(
    parameter int REG_FILE_DEPTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 alu_wb_valid_i,
    input  t_register_addr       alu_wb_addr_i,
    input  logic [DATA_32_W-1:0] alu_wb_data_i,
    output logic                 alu_wb_ready_o,
    input  logic                 lsu_wb_valid_i,
    input  t_register_addr       lsu_wb_addr_i,
    input  logic [DATA_32_W-1:0] lsu_wb_data_i,
    output logic                 lsu_wb_ready_o,
    output logic                 reg_file_write_o,
    output t_register_addr       reg_file_wr_addr_o,
    output logic [DATA_32_W-1:0] reg_file_wr_data_o,
`ifdef MIKE_WB_BYPASS_EN
    input  t_register_addr       byp_rd_addr_1_i,
    input  t_register_addr       byp_rd_addr_2_i,
    output logic                 byp_hit_1_o,
    output logic                 byp_hit_2_o,
    output logic [DATA_32_W-1:0] byp_data_1_o,
    output logic [DATA_32_W-1:0] byp_data_2_o,
`endif
    output logic                 wb_addr_err_o
);

    t_wb_req               alu_req_s;
    t_wb_req               lsu_req_s;
    t_wb_req               sel_req_s;
    logic [WB_NUM_SRC-1:0] gnt_s;
    logic                  grant_any_s;
    logic                  in_range_s;

    logic                  wr_q,   wr_d;
    t_register_addr        addr_q, addr_d;
    logic [DATA_32_W-1:0]  data_q, data_d;
    logic                  err_q,  err_d;

    assign alu_req_s = '{valid: alu_wb_valid_i, addr: alu_wb_addr_i, data: alu_wb_data_i};
    assign lsu_req_s = '{valid: lsu_wb_valid_i, addr: lsu_wb_addr_i, data: lsu_wb_data_i};

    risc_v_mike_rr_arb2 u_rr_arb2 (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req_i ({lsu_req_s.valid, alu_req_s.valid}),
        .gnt_o (gnt_s)
    );

    assign alu_wb_ready_o = gnt_s[0];
    assign lsu_wb_ready_o = gnt_s[1];

    // Stage next-state: x0 and out-of-range writes are accepted but never committed.
    always_comb begin
        sel_req_s   = gnt_s[1] ? lsu_req_s : alu_req_s;
        grant_any_s = (|gnt_s) & sel_req_s.valid;
        in_range_s  = addr_in_range(sel_req_s.addr, REG_FILE_DEPTH);
        wr_d   = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        err_d  = err_q;
        if (grant_any_s) begin
            if (in_range_s && (sel_req_s.addr != 5'd0)) begin
                wr_d   = 1'b1;
                addr_d = sel_req_s.addr;
                data_d = sel_req_s.data;
            end else begin
                wr_d = 1'b0;
            end
            err_d = err_q | ~in_range_s;
        end else begin
            wr_d = 1'b0;
        end
    end

    // One-deep output stage; reset discards any accepted-but-uncommitted write.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q   <= 1'b0;
            addr_q <= 5'd0;
            data_q <= 32'd0;
            err_q  <= 1'b0;
        end else begin
            wr_q   <= wr_d;
            addr_q <= addr_d;
            data_q <= data_d;
            err_q  <= err_d;
        end
    end

    assign reg_file_write_o   = wr_q;
    assign reg_file_wr_addr_o = addr_q;
    assign reg_file_wr_data_o = data_q;
    assign wb_addr_err_o      = err_q;

`ifdef MIKE_WB_BYPASS_EN
    assign byp_hit_1_o  = wr_q & (byp_rd_addr_1_i == addr_q);
    assign byp_hit_2_o  = wr_q & (byp_rd_addr_2_i == addr_q);
    assign byp_data_1_o = data_q;
    assign byp_data_2_o = data_q;
`endif

endmodule
